// File: rtl/mbinit_pkg.sv
// rtl/mbinit_pkg.sv - shared constants and types for the MBINIT sequencer slice
//
// Purpose: stage index constants, bus widths and the sequencer state enum
// shared by mbinit_sequencer and its sub-modules.
// Ports: none (package).
package mbinit_pkg;

  localparam int NUM_STAGES = 6;
  localparam int SB_MSG_W   = 4;

  localparam logic [2:0] STG_PARAM      = 3'd0;
  localparam logic [2:0] STG_CAL        = 3'd1;
  localparam logic [2:0] STG_REPAIRCLK  = 3'd2;
  localparam logic [2:0] STG_REPAIRVAL  = 3'd3;
  localparam logic [2:0] STG_REVERSALMB = 3'd4;
  localparam logic [2:0] STG_REPAIRMB   = 3'd5;
  localparam logic [2:0] STG_NONE       = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STAGE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mbinit_timeout_counter.sv
// rtl/mbinit_timeout_counter.sv - saturating per-stage timeout counter
//
// Purpose: counts cycles while enabled, restarts from 0 on clear, and flags
// the last permitted cycle of a stage.
// Ports:
//   CLK, rst_n  clock, asynchronous active-low reset
//   clear       restart count at 0 (wins over enable)
//   enable      count this cycle
//   expire      high while enabled and count == TIMEOUT_CYCLES-1
module mbinit_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int TIMEOUT_W      = 20
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] count;

  // Holds at LAST instead of wrapping, so expire stays asserted until the
  // sequencer leaves the stage.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/mbinit_sequencer.sv
// rtl/mbinit_sequencer.sv - MBINIT sub-state sequencer with shared sideband path
//
// Purpose: enables the six MBINIT stages one at a time in fixed order, shares
// the sideband TX/RX path with the active stage, enforces a per-stage timeout
// and reports done / train error to the LTSM.
// Ports:
//   CLK, rst_n          clock, asynchronous active-low reset
//   i_mbinit_start      level: run (1) / abort to IDLE (0)
//   i_stage_end         per-stage end flags
//   i_stage_error       per-stage train-error requests
//   i_stage_tx_msg      packed per-stage TX messages, stage k at [4k+3:4k]
//   i_stage_tx_valid    per-stage TX valids
//   i_rx_msg_valid      sideband RX valid
//   o_stage_en          one-hot stage enable
//   o_active_stage      enabled stage index, 7 when none
//   o_tx_msg/o_tx_stage/o_tx_valid  registered TX mux output
//   o_rx_msg_valid      RX valid routed to the active stage
//   o_mbinit_done       held high in DONE
//   o_train_error_req   held high in ERROR
module mbinit_sequencer
  import mbinit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int TIMEOUT_W      = 20
) (
  input  logic                           CLK,
  input  logic                           rst_n,
  input  logic                           i_mbinit_start,
  input  logic [NUM_STAGES-1:0]          i_stage_end,
  input  logic [NUM_STAGES-1:0]          i_stage_error,
  input  logic [NUM_STAGES*SB_MSG_W-1:0] i_stage_tx_msg,
  input  logic [NUM_STAGES-1:0]          i_stage_tx_valid,
  input  logic                           i_rx_msg_valid,
  output logic [NUM_STAGES-1:0]          o_stage_en,
  output logic [2:0]                     o_active_stage,
  output logic [SB_MSG_W-1:0]            o_tx_msg,
  output logic [2:0]                     o_tx_stage,
  output logic                           o_tx_valid,
  output logic [NUM_STAGES-1:0]          o_rx_msg_valid,
  output logic                           o_mbinit_done,
  output logic                           o_train_error_req
);

  seq_state_e state, state_nxt;
  logic [2:0] stage, stage_nxt;
  logic       timer_clear, timer_en, timer_expire;
  logic       tx_sel_valid;
  logic [SB_MSG_W-1:0] tx_sel_msg;

  mbinit_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_W     (TIMEOUT_W)
  ) u_timeout (
    .CLK   (CLK),
    .rst_n (rst_n),
    .clear (timer_clear),
    .enable(timer_en),
    .expire(timer_expire)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      stage <= STG_PARAM;
    end else begin
      state <= state_nxt;
      stage <= stage_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    stage_nxt         = stage;
    o_stage_en        = '0;
    o_active_stage    = STG_NONE;
    o_mbinit_done     = 1'b0;
    o_train_error_req = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_mbinit_start) begin
          state_nxt = ST_STAGE;
          stage_nxt = STG_PARAM;
        end
      end
      ST_STAGE: begin
        o_stage_en     = NUM_STAGES'(1) << stage;
        o_active_stage = stage;
        // Priority: abort > error > end > timeout; only the active stage's
        // flags are looked at.
        if (!i_mbinit_start) begin
          state_nxt = ST_IDLE;
        end else if (i_stage_error[stage]) begin
          state_nxt = ST_ERROR;
        end else if (i_stage_end[stage]) begin
          if (stage == STG_REPAIRMB) begin
            state_nxt = ST_DONE;
          end else begin
            stage_nxt = stage + 3'd1;
          end
        end else if (timer_expire) begin
          state_nxt = ST_ERROR;
        end
      end
      ST_DONE: begin
        o_mbinit_done = 1'b1;
        if (!i_mbinit_start) state_nxt = ST_IDLE;
      end
      ST_ERROR: begin
        o_train_error_req = 1'b1;
        if (!i_mbinit_start) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A stage-to-stage advance is a state change too, so the next stage
  // starts its timeout budget from zero.
  assign timer_clear = (state_nxt != state) || (stage_nxt != stage);
  assign timer_en    = (state == ST_STAGE);

  // TX mux samples the currently enabled stage; on a transition edge that is
  // the outgoing stage, so the incoming stage's message lags by one cycle.
  assign tx_sel_valid = (state == ST_STAGE) && i_stage_tx_valid[stage];
  assign tx_sel_msg   = i_stage_tx_msg[{stage, 2'b00} +: SB_MSG_W];

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      o_tx_msg   <= '0;
      o_tx_stage <= '0;
      o_tx_valid <= 1'b0;
    end else begin
      o_tx_valid <= tx_sel_valid;
      o_tx_msg   <= tx_sel_valid ? tx_sel_msg : '0;
      o_tx_stage <= tx_sel_valid ? stage : 3'd0;
    end
  end

  assign o_rx_msg_valid = ((state == ST_STAGE) && i_rx_msg_valid) ?
                          (NUM_STAGES'(1) << stage) : '0;

endmodule

// File: tb/tb_mbinit_sequencer.sv
// tb/tb_mbinit_sequencer.sv - directed scoreboard bench for mbinit_sequencer
module tb_mbinit_sequencer;
  import mbinit_pkg::*;

  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  st_end = '0;
  logic [5:0]  st_err = '0;
  logic [23:0] tx_msg_in = '0;
  logic [5:0]  tx_valid_in = '0;
  logic        rx_v = 1'b0;

  logic [5:0]  stage_en;
  logic [2:0]  active_stage;
  logic [3:0]  tx_msg;
  logic [2:0]  tx_stage;
  logic        tx_valid;
  logic [5:0]  rx_valid;
  logic        done;
  logic        train_err;

  mbinit_sequencer #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(5)) dut (
    .CLK              (CLK),
    .rst_n            (rst_n),
    .i_mbinit_start   (start),
    .i_stage_end      (st_end),
    .i_stage_error    (st_err),
    .i_stage_tx_msg   (tx_msg_in),
    .i_stage_tx_valid (tx_valid_in),
    .i_rx_msg_valid   (rx_v),
    .o_stage_en       (stage_en),
    .o_active_stage   (active_stage),
    .o_tx_msg         (tx_msg),
    .o_tx_stage       (tx_stage),
    .o_tx_valid       (tx_valid),
    .o_rx_msg_valid   (rx_valid),
    .o_mbinit_done    (done),
    .o_train_error_req(train_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic exp_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic go_stage(input int k);
    start = 1'b1;
    step();
    for (int j = 0; j < k; j++) begin
      st_end = 6'(1 << j);
      step();
      st_end = '0;
    end
    exp_push("go_active", 32'(k));
    chk(32'(active_stage));
  endtask

  task automatic check_idle(input string tag);
    exp_push({tag, "_en"}, 32'd0);
    exp_push({tag, "_active"}, 32'd7);
    chk(32'(stage_en));
    chk(32'(active_stage));
  endtask

  initial begin
    // Reset state
    step();
    step();
    exp_push("rst_en", 32'd0);
    exp_push("rst_active", 32'd7);
    exp_push("rst_tx_valid", 32'd0);
    exp_push("rst_done", 32'd0);
    exp_push("rst_err", 32'd0);
    chk(32'(stage_en));
    chk(32'(active_stage));
    chk(32'(tx_valid));
    chk(32'(done));
    chk(32'(train_err));
    rst_n = 1'b1;
    step();

    // No stage active: TX mux must stay quiet
    tx_valid_in = 6'h3f;
    tx_msg_in   = 24'hffffff;
    step();
    exp_push("idle_tx_valid", 32'd0);
    exp_push("idle_tx_msg", 32'd0);
    chk(32'(tx_valid));
    chk(32'(tx_msg));
    tx_valid_in = '0;
    tx_msg_in   = '0;

    // Normal run with end pulses 3 cycles after each enable rises
    start = 1'b1;
    step();
    for (int k = 0; k < 6; k++) begin
      exp_push("run_en", 32'(1 << k));
      chk(32'(stage_en));
      if (k == 0) begin
        st_end = 6'b100000;
        st_err = 6'b010000;
      end
      if (k == 3) begin
        tx_valid_in = 6'b001010;
        tx_msg_in   = 24'h005020;
        rx_v        = 1'b1;
        #1;
        exp_push("rx_route", 32'b001000);
        chk(32'(rx_valid));
      end
      step();
      if (k == 0) begin
        exp_push("ignore_other_stages", 32'd1);
        chk(32'(stage_en));
        st_end = '0;
        st_err = '0;
      end
      if (k == 3) begin
        exp_push("tx_msg", 32'h5);
        exp_push("tx_stage", 32'd3);
        exp_push("tx_valid", 32'd1);
        chk(32'(tx_msg));
        chk(32'(tx_stage));
        chk(32'(tx_valid));
        tx_valid_in = '0;
        tx_msg_in   = '0;
        rx_v        = 1'b0;
      end
      step();
      st_end = 6'(1 << k);
      step();
      st_end = '0;
    end
    exp_push("done", 32'd1);
    chk(32'(done));
    check_idle("done");
    step();
    exp_push("done_held", 32'd1);
    chk(32'(done));
    start = 1'b0;
    step();
    exp_push("done_to_idle", 32'd0);
    chk(32'(done));
    check_idle("done_idle");

    // Timeout on stage 2
    go_stage(2);
    for (int i = 0; i < TO; i++) begin
      exp_push("timeout_en", 32'b000100);
      chk(32'(stage_en));
      step();
    end
    exp_push("timeout_err", 32'd1);
    chk(32'(train_err));
    check_idle("timeout");
    st_end = 6'h3f;
    step();
    st_end = '0;
    exp_push("err_held", 32'd1);
    chk(32'(train_err));
    start = 1'b0;
    step();
    exp_push("err_to_idle", 32'd0);
    chk(32'(train_err));

    // Error and end in the same cycle: error wins
    go_stage(3);
    st_err = 6'b001000;
    st_end = 6'b001000;
    step();
    st_err = '0;
    st_end = '0;
    exp_push("err_vs_end", 32'd1);
    chk(32'(train_err));
    step();
    exp_push("no_en4", 32'd0);
    chk(32'(stage_en));
    start = 1'b0;
    step();

    // Abort beats error
    go_stage(0);
    start  = 1'b0;
    st_err = 6'b000001;
    step();
    st_err = '0;
    exp_push("abort_over_err", 32'd0);
    chk(32'(train_err));
    check_idle("abort_prio");

    // Abort during stage 4
    go_stage(4);
    start = 1'b0;
    step();
    check_idle("abort4");

    // Asynchronous reset mid-stage
    go_stage(1);
    tx_valid_in = 6'b000010;
    tx_msg_in   = 24'h000090;
    step();
    exp_push("pre_rst_tx_msg", 32'h9);
    chk(32'(tx_msg));
    #1;
    rst_n = 1'b0;
    #1;
    exp_push("arst_tx_valid", 32'd0);
    exp_push("arst_tx_msg", 32'd0);
    exp_push("arst_tx_stage", 32'd0);
    chk(32'(tx_valid));
    chk(32'(tx_msg));
    chk(32'(tx_stage));
    check_idle("arst");
    start       = 1'b0;
    tx_valid_in = '0;
    step();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
